// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the memory-access stage and its alignment helper:
// access-size encodings, exception cause codes and the LSU state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package rv_pkg;

    // Access size as carried by the load/store funct3[1:0]
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Machine exception cause codes raised by the memory stage
    localparam logic [4:0] LD_MISALIGN = 5'd4;
    localparam logic [4:0] LD_FAULT    = 5'd5;
    localparam logic [4:0] ST_MISALIGN = 5'd6;
    localparam logic [4:0] ST_FAULT    = 5'd7;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_RD = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for sub-word memory accesses.
//   size        : access size (byte/half/word, 3 behaves as word)
//   addr_lo     : address bits [1:0]
//   is_unsigned : zero-extend instead of sign-extend loaded data
//   wdata       : store data from the register file
//   rdata       : raw word returned by the RAM
//   be          : byte enables for the addressed lanes
//   wdata_out   : store data replicated into every lane
//   rdata_out   : loaded value shifted down and extended to 32 bits
// ---------------------------------------------------------------------------
module lsu_align
    import rv_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [31:0] sh;
    logic        sign_b;
    logic        sign_h;

    // Replicating the store data means the RAM can pick any lane by byte
    // enable alone, with no shifter on the write path.
    always_comb begin
        sh     = rdata >> {addr_lo, 3'b000};
        sign_b = ~is_unsigned & sh[7];
        sign_h = ~is_unsigned & sh[15];
        case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_out = {4{wdata[7:0]}};
                rdata_out = {{24{sign_b}}, sh[7:0]};
            end
            SIZE_HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata_out = {2{wdata[15:0]}};
                rdata_out = {{16{sign_h}}, sh[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata_out = wdata;
                rdata_out = sh;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu
// Memory-access stage of the 5-stage pipeline. Issues load/store requests
// on the data-RAM port, stalls the pipeline while a transaction is open,
// and reports misaligned and timed-out accesses as exceptions.
//   clk, cpurst        : clock and synchronous active-high reset
//   exe2mem_*          : instruction arriving from the execute stage
//   dram_req/we/addr/be/wdata : RAM request channel
//   dram_gnt           : request accepted this cycle
//   dram_rvalid/rdata  : RAM read response
//   readram_stall      : hold upstream, bubble downstream
//   mem2wb_*           : combinational results valid in the completion cycle
// ---------------------------------------------------------------------------
module mem_lsu
    import rv_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        exe2mem_valid,
    input  logic        exe2mem_load,
    input  logic        exe2mem_store,
    input  logic [1:0]  exe2mem_size,
    input  logic        exe2mem_unsigned,
    input  logic [31:0] exe2mem_addr,
    input  logic [31:0] exe2mem_wdata,
    input  logic [31:0] exe2mem_alu_result,
    input  logic        exe2mem_wr_reg,
    input  logic [4:0]  exe2mem_wr_regindex,
    input  logic [31:0] exe2mem_pc,
    input  logic        exe2mem_exp,
    input  logic [4:0]  exe2mem_causecode,
    input  logic [31:0] exe2mem_mtval,
    output logic        dram_req,
    output logic        dram_we,
    output logic [31:0] dram_addr,
    output logic [3:0]  dram_be,
    output logic [31:0] dram_wdata,
    input  logic        dram_gnt,
    input  logic        dram_rvalid,
    input  logic [31:0] dram_rdata,
    output logic        readram_stall,
    output logic        mem2wb_wr_reg,
    output logic [4:0]  mem2wb_wr_regindex,
    output logic [31:0] mem2wb_wr_wdata,
    output logic [31:0] mem2wb_pc,
    output logic        mem2wb_exp,
    output logic [4:0]  mem2wb_causecode,
    output logic [31:0] mem2wb_mtval
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        aligned;
    logic        memop;
    logic        misalign;
    logic        done_ok;
    logic        timeout;
    logic        complete;
    logic [31:0] load_data;

    lsu_align u_align (
        .size        (exe2mem_size),
        .addr_lo     (exe2mem_addr[1:0]),
        .is_unsigned (exe2mem_unsigned),
        .wdata       (exe2mem_wdata),
        .rdata       (dram_rdata),
        .be          (dram_be),
        .wdata_out   (dram_wdata),
        .rdata_out   (load_data)
    );

    // Access classification. A load flag wins if both flags are ever set,
    // so the store path never sees an ambiguous instruction.
    always_comb begin
        is_load  = exe2mem_load;
        is_store = exe2mem_store & ~exe2mem_load;
        case (exe2mem_size)
            SIZE_BYTE: aligned = 1'b1;
            SIZE_HALF: aligned = ~exe2mem_addr[0];
            default:   aligned = (exe2mem_addr[1:0] == 2'b00);
        endcase
        is_mem   = exe2mem_valid & (is_load | is_store) & ~exe2mem_exp;
        memop    = is_mem & aligned;
        misalign = is_mem & ~aligned;
        done_ok  = memop & (((state == ST_IDLE) & is_store & dram_gnt) |
                            ((state == ST_WAIT_RD) & dram_rvalid));
        // The timeout only fires when nothing else finishes the access in
        // the same cycle, so a response on the last allowed cycle still wins.
        timeout  = memop & (cnt == CNT_LAST) & ~done_ok;
        complete = done_ok | timeout;
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A granted load that also hits the timeout is abandoned, so its
    // response arrives in IDLE and is dropped there.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:
                if (memop & is_load & dram_gnt & ~timeout)
                    state_next = ST_WAIT_RD;
            ST_WAIT_RD:
                if (~memop | complete)
                    state_next = ST_IDLE;
            default:
                state_next = ST_IDLE;
        endcase
        cnt_next = readram_stall ? cnt + 1'b1 : '0;
    end

    // RAM request channel and writeback results. Exceptions and stores
    // never write the register file.
    always_comb begin
        readram_stall      = memop & ~complete;
        dram_req           = memop & (state == ST_IDLE);
        dram_we            = memop & is_store;
        dram_addr          = {exe2mem_addr[31:2], 2'b00};
        mem2wb_pc          = exe2mem_pc;
        mem2wb_wr_reg      = 1'b0;
        mem2wb_wr_regindex = '0;
        mem2wb_wr_wdata    = '0;
        mem2wb_exp         = 1'b0;
        mem2wb_causecode   = '0;
        mem2wb_mtval       = '0;
        if (exe2mem_valid) begin
            mem2wb_wr_regindex = exe2mem_wr_regindex;
            if (exe2mem_exp) begin
                mem2wb_exp       = 1'b1;
                mem2wb_causecode = exe2mem_causecode;
                mem2wb_mtval     = exe2mem_mtval;
            end else if (misalign) begin
                mem2wb_exp       = 1'b1;
                mem2wb_causecode = is_load ? LD_MISALIGN : ST_MISALIGN;
                mem2wb_mtval     = exe2mem_addr;
            end else if (timeout) begin
                mem2wb_exp       = 1'b1;
                mem2wb_causecode = is_load ? LD_FAULT : ST_FAULT;
                mem2wb_mtval     = exe2mem_addr;
            end else if (memop) begin
                if (is_load) begin
                    mem2wb_wr_reg   = exe2mem_wr_reg & ~readram_stall;
                    mem2wb_wr_wdata = load_data;
                end
            end else begin
                mem2wb_wr_reg   = exe2mem_wr_reg;
                mem2wb_wr_wdata = exe2mem_alu_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu
// Directed testbench for the memory-access stage: aligned loads and stores,
// sign/zero extension, misalignment, timeouts and reset during a read.
// ---------------------------------------------------------------------------
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        exe2mem_valid, exe2mem_load, exe2mem_store, exe2mem_unsigned;
    logic [1:0]  exe2mem_size;
    logic [31:0] exe2mem_addr, exe2mem_wdata, exe2mem_alu_result, exe2mem_pc, exe2mem_mtval;
    logic        exe2mem_wr_reg, exe2mem_exp;
    logic [4:0]  exe2mem_wr_regindex, exe2mem_causecode;
    logic        dram_req, dram_we, dram_gnt, dram_rvalid;
    logic [31:0] dram_addr, dram_wdata, dram_rdata;
    logic [3:0]  dram_be;
    logic        readram_stall;
    logic        mem2wb_wr_reg, mem2wb_exp;
    logic [4:0]  mem2wb_wr_regindex, mem2wb_causecode;
    logic [31:0] mem2wb_wr_wdata, mem2wb_pc, mem2wb_mtval;

    int checks = 0;
    int errors = 0;
    int n;

    mem_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk                 (clk),
        .cpurst              (cpurst),
        .exe2mem_valid       (exe2mem_valid),
        .exe2mem_load        (exe2mem_load),
        .exe2mem_store       (exe2mem_store),
        .exe2mem_size        (exe2mem_size),
        .exe2mem_unsigned    (exe2mem_unsigned),
        .exe2mem_addr        (exe2mem_addr),
        .exe2mem_wdata       (exe2mem_wdata),
        .exe2mem_alu_result  (exe2mem_alu_result),
        .exe2mem_wr_reg      (exe2mem_wr_reg),
        .exe2mem_wr_regindex (exe2mem_wr_regindex),
        .exe2mem_pc          (exe2mem_pc),
        .exe2mem_exp         (exe2mem_exp),
        .exe2mem_causecode   (exe2mem_causecode),
        .exe2mem_mtval       (exe2mem_mtval),
        .dram_req            (dram_req),
        .dram_we             (dram_we),
        .dram_addr           (dram_addr),
        .dram_be             (dram_be),
        .dram_wdata          (dram_wdata),
        .dram_gnt            (dram_gnt),
        .dram_rvalid         (dram_rvalid),
        .dram_rdata          (dram_rdata),
        .readram_stall       (readram_stall),
        .mem2wb_wr_reg       (mem2wb_wr_reg),
        .mem2wb_wr_regindex  (mem2wb_wr_regindex),
        .mem2wb_wr_wdata     (mem2wb_wr_wdata),
        .mem2wb_pc           (mem2wb_pc),
        .mem2wb_exp          (mem2wb_exp),
        .mem2wb_causecode    (mem2wb_causecode),
        .mem2wb_mtval        (mem2wb_mtval)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        exe2mem_valid       = 1'b0;
        exe2mem_load        = 1'b0;
        exe2mem_store       = 1'b0;
        exe2mem_size        = 2'd0;
        exe2mem_unsigned    = 1'b0;
        exe2mem_addr        = 32'h0;
        exe2mem_wdata       = 32'h0;
        exe2mem_alu_result  = 32'h0;
        exe2mem_wr_reg      = 1'b0;
        exe2mem_wr_regindex = 5'd0;
        exe2mem_pc          = 32'h0000_0800;
        exe2mem_exp         = 1'b0;
        exe2mem_causecode   = 5'd0;
        exe2mem_mtval       = 32'h0;
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        exe2mem_valid       = 1'b1;
        exe2mem_load        = ld;
        exe2mem_store       = st;
        exe2mem_size        = size;
        exe2mem_unsigned    = uns;
        exe2mem_addr        = addr;
        exe2mem_wdata       = wdata;
        exe2mem_alu_result  = 32'h0BAD_0BAD;
        exe2mem_wr_reg      = 1'b1;
        exe2mem_wr_regindex = 5'd10;
        exe2mem_pc          = 32'h0000_2000 + addr;
        exe2mem_exp         = 1'b0;
        exe2mem_causecode   = 5'd0;
        exe2mem_mtval       = 32'h0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the falling edge, 4 units later.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic runLoad(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] expected);
        applyStimulus(1'b1, 1'b0, size, uns, addr, 32'h0);
        dram_gnt = 1'b1;
        #4;
        checkOutput({tag, " req"}, {31'b0, dram_req}, 32'd1);
        nextCycle();
        dram_gnt    = 1'b0;
        dram_rvalid = 1'b1;
        dram_rdata  = rdata;
        #4;
        checkOutput({tag, " data"}, mem2wb_wr_wdata, expected);
        checkOutput({tag, " stall"}, {31'b0, readram_stall}, 32'd0);
        nextCycle();
        dram_rvalid = 1'b0;
        idleInputs();
    endtask

    initial begin
        cpurst      = 1'b1;
        dram_gnt    = 1'b0;
        dram_rvalid = 1'b0;
        dram_rdata  = 32'h0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        cpurst = 1'b0;
        #4;
        checkOutput("reset req", {31'b0, dram_req}, 32'd0);
        checkOutput("reset stall", {31'b0, readram_stall}, 32'd0);
        checkOutput("reset wr_reg", {31'b0, mem2wb_wr_reg}, 32'd0);
        checkOutput("invalid exp", {31'b0, mem2wb_exp}, 32'd0);
        checkOutput("invalid pc", mem2wb_pc, 32'h0000_0800);

        // lw 0x100: grant now, data two cycles later
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        dram_gnt = 1'b1;
        #4;
        checkOutput("lw req", {31'b0, dram_req}, 32'd1);
        checkOutput("lw we", {31'b0, dram_we}, 32'd0);
        checkOutput("lw stall c0", {31'b0, readram_stall}, 32'd1);
        nextCycle();
        dram_gnt = 1'b0;
        #4;
        checkOutput("lw stall c1", {31'b0, readram_stall}, 32'd1);
        checkOutput("lw req wait", {31'b0, dram_req}, 32'd0);
        nextCycle();
        dram_rvalid = 1'b1;
        dram_rdata  = 32'hDEAD_BEEF;
        #4;
        checkOutput("lw stall done", {31'b0, readram_stall}, 32'd0);
        checkOutput("lw data", mem2wb_wr_wdata, 32'hDEAD_BEEF);
        checkOutput("lw wr_reg", {31'b0, mem2wb_wr_reg}, 32'd1);
        checkOutput("lw regindex", {27'b0, mem2wb_wr_regindex}, 32'd10);
        checkOutput("lw be", {28'b0, dram_be}, 32'hF);
        checkOutput("lw addr", dram_addr, 32'h100);
        nextCycle();
        dram_rvalid = 1'b0;
        idleInputs();

        // Sub-word loads from the same RAM word
        runLoad("lb 203", 2'd0, 1'b0, 32'h203, 32'h8012_3456, 32'hFFFF_FF80);
        runLoad("lbu 203", 2'd0, 1'b1, 32'h203, 32'h8012_3456, 32'h0000_0080);
        runLoad("lhu 202", 2'd1, 1'b1, 32'h202, 32'h8012_3456, 32'h0000_8012);
        runLoad("lh 202", 2'd1, 1'b0, 32'h202, 32'h8012_3456, 32'hFFFF_8012);
        runLoad("lb 200", 2'd0, 1'b0, 32'h200, 32'h8012_3456, 32'h0000_0056);

        // sh 0x102 with immediate grant
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234_ABCD);
        dram_gnt = 1'b1;
        #4;
        checkOutput("sh be", {28'b0, dram_be}, 32'hC);
        checkOutput("sh wdata", dram_wdata, 32'hABCD_ABCD);
        checkOutput("sh we", {31'b0, dram_we}, 32'd1);
        checkOutput("sh req", {31'b0, dram_req}, 32'd1);
        checkOutput("sh stall", {31'b0, readram_stall}, 32'd0);
        checkOutput("sh wr_reg", {31'b0, mem2wb_wr_reg}, 32'd0);
        checkOutput("sh addr", dram_addr, 32'h100);
        nextCycle();

        // sb 0x101
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00EF);
        #4;
        checkOutput("sb be", {28'b0, dram_be}, 32'h2);
        checkOutput("sb wdata", dram_wdata, 32'hEFEF_EFEF);
        nextCycle();
        dram_gnt = 1'b0;

        // Misaligned accesses
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h1001, 32'h0);
        #4;
        checkOutput("lw mis req", {31'b0, dram_req}, 32'd0);
        checkOutput("lw mis exp", {31'b0, mem2wb_exp}, 32'd1);
        checkOutput("lw mis cause", {27'b0, mem2wb_causecode}, 32'd4);
        checkOutput("lw mis mtval", mem2wb_mtval, 32'h1001);
        checkOutput("lw mis stall", {31'b0, readram_stall}, 32'd0);
        checkOutput("lw mis wr_reg", {31'b0, mem2wb_wr_reg}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h1002, 32'h0);
        #4;
        checkOutput("sw mis cause", {27'b0, mem2wb_causecode}, 32'd6);
        checkOutput("sw mis mtval", mem2wb_mtval, 32'h1002);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'd1, 1'b0, 32'h1003, 32'h0);
        #4;
        checkOutput("lh mis cause", {27'b0, mem2wb_causecode}, 32'd4);
        nextCycle();

        // Non-memory instruction
        idleInputs();
        exe2mem_valid       = 1'b1;
        exe2mem_alu_result  = 32'h1234_5678;
        exe2mem_wr_reg      = 1'b1;
        exe2mem_wr_regindex = 5'd7;
        #4;
        checkOutput("alu data", mem2wb_wr_wdata, 32'h1234_5678);
        checkOutput("alu wr_reg", {31'b0, mem2wb_wr_reg}, 32'd1);
        checkOutput("alu regindex", {27'b0, mem2wb_wr_regindex}, 32'd7);
        checkOutput("alu req", {31'b0, dram_req}, 32'd0);
        nextCycle();

        // Earlier exception passes through
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
        exe2mem_exp       = 1'b1;
        exe2mem_causecode = 5'd2;
        exe2mem_mtval     = 32'h0000_0ABC;
        #4;
        checkOutput("prior exp", {31'b0, mem2wb_exp}, 32'd1);
        checkOutput("prior cause", {27'b0, mem2wb_causecode}, 32'd2);
        checkOutput("prior mtval", mem2wb_mtval, 32'h0000_0ABC);
        checkOutput("prior wr_reg", {31'b0, mem2wb_wr_reg}, 32'd0);
        checkOutput("prior req", {31'b0, dram_req}, 32'd0);
        nextCycle();

        // Load timeout: granted, never answered
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
        dram_gnt = 1'b1;
        n = 0;
        #4;
        while (readram_stall && n < 40) begin
            n++;
            nextCycle();
            dram_gnt = 1'b0;
            #4;
        end
        checkOutput("ld timeout stalls", n, 32'd15);
        checkOutput("ld timeout exp", {31'b0, mem2wb_exp}, 32'd1);
        checkOutput("ld timeout cause", {27'b0, mem2wb_causecode}, 32'd5);
        checkOutput("ld timeout mtval", mem2wb_mtval, 32'h300);
        checkOutput("ld timeout wr_reg", {31'b0, mem2wb_wr_reg}, 32'd0);
        nextCycle();
        idleInputs();
        dram_rvalid = 1'b1;
        dram_rdata  = 32'h7777_7777;
        #4;
        checkOutput("late rvalid wr_reg", {31'b0, mem2wb_wr_reg}, 32'd0);
        checkOutput("late rvalid stall", {31'b0, readram_stall}, 32'd0);
        nextCycle();
        dram_rvalid = 1'b0;
        runLoad("lw after timeout", 2'd2, 1'b0, 32'h104, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Store timeout: never granted
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h500, 32'h1111_2222);
        n = 0;
        #4;
        while (readram_stall && n < 40) begin
            n++;
            nextCycle();
            #4;
        end
        checkOutput("st timeout stalls", n, 32'd15);
        checkOutput("st timeout cause", {27'b0, mem2wb_causecode}, 32'd7);
        checkOutput("st timeout mtval", mem2wb_mtval, 32'h500);
        nextCycle();
        idleInputs();

        // Reset while waiting for read data
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        dram_gnt = 1'b1;
        nextCycle();
        dram_gnt = 1'b0;
        cpurst   = 1'b1;
        #4;
        checkOutput("pre-reset stall", {31'b0, readram_stall}, 32'd1);
        nextCycle();
        cpurst = 1'b0;
        idleInputs();
        dram_rvalid = 1'b1;
        dram_rdata  = 32'h5555_5555;
        #4;
        checkOutput("post-reset stall", {31'b0, readram_stall}, 32'd0);
        checkOutput("post-reset wr_reg", {31'b0, mem2wb_wr_reg}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        #4;
        checkOutput("stray rvalid stall", {31'b0, readram_stall}, 32'd1);
        checkOutput("stray rvalid req", {31'b0, dram_req}, 32'd1);
        nextCycle();
        dram_rvalid = 1'b0;
        dram_gnt    = 1'b1;
        nextCycle();
        dram_gnt    = 1'b0;
        dram_rvalid = 1'b1;
        dram_rdata  = 32'h1122_3344;
        #4;
        checkOutput("reissued lw data", mem2wb_wr_wdata, 32'h1122_3344);
        checkOutput("reissued lw stall", {31'b0, readram_stall}, 32'd0);
        nextCycle();
        dram_rvalid = 1'b0;
        idleInputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
